fetch_stage: RTL and testbench

Instruction fetch stage of the 5-stage MIPS datapath. Owns the PC, runs a held-request handshake to instruction memory, and absorbs hazard-unit stalls with a one-entry hold buffer. Applies branch/jump redirects and drives the IF/ID pipeline register. IF/ID Imm16 feeds the decode-stage 16→32 sign extender directly.

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_if_id_reg.sv | 46 ++++
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage:
// FSM state encoding, the NOP word and the default PC increment.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] C_NOP     = 32'h0000_0000;
    localparam logic [31:0] C_PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: reset/flush > stall > load; with none
// of those a bubble is inserted so decode never sees the same word twice.
// Ports: i_clk, i_rst, i_flush, i_stall, i_load, i_instr, i_pcplus4 in;
//        o_instr, o_pcplus4, o_valid out.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pcplus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pcplus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pcplus4;
    logic        r_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_instr   <= C_NOP;
            r_pcplus4 <= 32'h0;
            r_valid   <= 1'b0;
        end else if (!i_stall) begin
            if (i_load) begin
                r_instr   <= i_instr;
                r_pcplus4 <= i_pcplus4;
                r_valid   <= 1'b1;
            end else begin
                r_instr   <= C_NOP;
                r_pcplus4 <= 32'h0;
                r_valid   <= 1'b0;
            end
        end
    end

    assign o_instr   = r_instr;
    assign o_pcplus4 = r_pcplus4;
    assign o_valid   = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, holds one imem request at a time,
// parks a stalled word in a one-entry buffer and applies branch/jump redirects.
// Ports: Clk, Rst, Stall, Flush, BranchTaken/Target, Jump/Target,
//        ImemReq/Addr/Rdata/Valid, IfIdInstr/PCPlus4/Imm16/Valid.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = C_PC_STEP
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemRdata,
    input  logic        ImemValid,
    output logic [31:0] IfIdInstr,
    output logic [31:0] IfIdPCPlus4,
    output logic [15:0] IfIdImm16,
    output logic        IfIdValid
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_addr;
    logic [31:0]  r_hb_instr;
    logic [31:0]  r_hb_pc4;

    logic [31:0]  w_pc_nxt;
    logic [31:0]  w_req_nxt;
    logic         w_hb_we;
    logic         w_load;
    logic [31:0]  w_ld_instr;
    logic [31:0]  w_ld_pc4;

    logic         w_redir;
    logic [31:0]  w_target;
    logic [31:0]  w_seq;
    logic [31:0]  w_pc_inc;
    logic         w_blk;

    assign w_redir  = BranchTaken | Jump;
    assign w_target = BranchTaken ? BranchTarget : JumpTarget;
    assign w_seq    = r_req_addr + PC_STEP;
    assign w_pc_inc = r_pc + PC_STEP;
    // A word that cannot enter IF/ID this edge is parked, never lost.
    assign w_blk    = Stall | Flush;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_req_nxt   = r_req_addr;
        w_hb_we     = 1'b0;
        w_load      = 1'b0;
        w_ld_instr  = ImemRdata;
        w_ld_pc4    = w_seq;
        unique case (r_state)
            S_FETCH: begin
                if (w_redir) begin
                    w_pc_nxt = w_target;
                    // Address must stay stable until the
                    // outstanding request completes.
                    if (ImemValid) w_req_nxt = w_target;
                    else w_state_nxt = S_DISCARD;
                end else if (ImemValid) begin
                    w_pc_nxt  = w_pc_inc;
                    w_req_nxt = w_pc_inc;
                    if (w_blk) begin
                        w_hb_we     = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (w_redir) begin
                    w_pc_nxt    = w_target;
                    w_req_nxt   = w_target;
                    w_state_nxt = S_FETCH;
                end else if (!w_blk) begin
                    w_load      = 1'b1;
                    w_ld_instr  = r_hb_instr;
                    w_ld_pc4    = r_hb_pc4;
                    w_req_nxt   = r_pc;
                    w_state_nxt = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (w_redir) w_pc_nxt = w_target;
                if (ImemValid) begin
                    w_req_nxt   = w_pc_nxt;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= S_FETCH;
            r_pc       <= PC_RESET;
            r_req_addr <= PC_RESET;
            r_hb_instr <= C_NOP;
            r_hb_pc4   <= 32'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_nxt;
            if (w_hb_we) begin
                r_hb_instr <= ImemRdata;
                r_hb_pc4   <= w_seq;
            end
        end
    end

    assign ImemReq  = !Rst && (r_state != S_HOLD);
    assign ImemAddr = r_req_addr;

    if_id_reg u_if_id (
        .i_clk     (Clk),
        .i_rst     (Rst),
        .i_flush   (Flush),
        .i_stall   (Stall),
        .i_load    (w_load),
        .i_instr   (w_ld_instr),
        .i_pcplus4 (w_ld_pc4),
        .o_instr   (IfIdInstr),
        .o_pcplus4 (IfIdPCPlus4),
        .o_valid   (IfIdValid)
    );

    assign IfIdImm16 = IfIdInstr[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus
// hand-written reset-mid-request and PC wrap sequences.
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Stall;
    logic        Flush;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] ImemRdata;
    logic        ImemValid;
    logic [31:0] IfIdInstr;
    logic [31:0] IfIdPCPlus4;
    logic [15:0] IfIdImm16;
    logic        IfIdValid;

    int npass = 0;
    int ntot  = 0;

    fetch_stage dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (Stall),
        .Flush        (Flush),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemRdata    (ImemRdata),
        .ImemValid    (ImemValid),
        .IfIdInstr    (IfIdInstr),
        .IfIdPCPlus4  (IfIdPCPlus4),
        .IfIdImm16    (IfIdImm16),
        .IfIdValid    (IfIdValid)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jt;
        logic        vld;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        logic s, logic f, logic b, logic [31:0] bt,
        logic j, logic [31:0] jt, logic v, logic [31:0] rd,
        logic er, logic [31:0] ea, logic ev,
        logic [31:0] ei, logic [31:0] ep);
        vec_t r;
        r.stall = s;  r.flush = f;  r.br = b;  r.brt = bt;
        r.jmp = j;    r.jt = jt;    r.vld = v; r.rdata = rd;
        r.e_req = er; r.e_addr = ea; r.e_v = ev;
        r.e_instr = ei; r.e_pc4 = ep;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)",
                      name, act, exp, $time);
    endtask

    // Drive one cycle's inputs just after the falling edge.
    task automatic cyc(logic s, logic f, logic b, logic [31:0] bt,
                       logic j, logic [31:0] jt, logic v, logic [31:0] rd);
        @(negedge Clk);
        Stall = s; Flush = f; BranchTaken = b; BranchTarget = bt;
        Jump = j; JumpTarget = jt; ImemValid = v; ImemRdata = rd;
        #1;
    endtask

    initial begin
        Rst = 1'b1;
        Stall = 0; Flush = 0; BranchTaken = 0; BranchTarget = 0;
        Jump = 0; JumpTarget = 0; ImemValid = 0; ImemRdata = 0;

        //        s f b brt     j jt      v rdata          req addr     v instr          pc4
        vt.push_back(mk(0,0,0,0,      0,0,      1,32'h0,        1,32'h0,  0,32'h0,        32'h0));
        vt.push_back(mk(0,0,0,0,      0,0,      1,32'h4,        1,32'h4,  1,32'h0,        32'h4));
        vt.push_back(mk(0,0,0,0,      0,0,      1,32'h8,        1,32'h8,  1,32'h4,        32'h8));
        vt.push_back(mk(0,0,0,0,      0,0,      0,32'h0,        1,32'hC,  1,32'h8,        32'hC));
        vt.push_back(mk(0,0,0,0,      0,0,      0,32'h0,        1,32'hC,  0,32'h0,        32'h0));
        vt.push_back(mk(0,0,0,0,      0,0,      1,32'hC,        1,32'hC,  0,32'h0,        32'h0));
        vt.push_back(mk(1,0,0,0,      0,0,      1,32'h2008FFFF, 1,32'h10, 1,32'hC,        32'h10));
        vt.push_back(mk(1,0,0,0,      0,0,      0,32'h0,        0,32'h14, 1,32'hC,        32'h10));
        vt.push_back(mk(0,0,0,0,      0,0,      0,32'h0,        0,32'h14, 1,32'hC,        32'h10));
        vt.push_back(mk(0,0,0,0,      0,0,      0,32'h0,        1,32'h14, 1,32'h2008FFFF, 32'h14));
        vt.push_back(mk(0,0,1,32'h40, 0,0,      0,32'h0,        1,32'h14, 0,32'h0,        32'h0));
        vt.push_back(mk(0,0,0,0,      0,0,      0,32'h0,        1,32'h14, 0,32'h0,        32'h0));
        vt.push_back(mk(0,0,0,0,      0,0,      1,32'hDEADBEEF, 1,32'h14, 0,32'h0,        32'h0));
        vt.push_back(mk(0,0,0,0,      0,0,      1,32'h40,       1,32'h40, 0,32'h0,        32'h0));
        vt.push_back(mk(0,0,1,32'h100,1,32'h200,1,32'h44,       1,32'h44, 1,32'h40,       32'h44));
        vt.push_back(mk(0,0,0,0,      0,0,      1,32'h100,      1,32'h100,0,32'h0,        32'h0));
        vt.push_back(mk(1,1,0,0,      0,0,      0,32'h0,        1,32'h104,1,32'h100,      32'h104));
        vt.push_back(mk(0,0,0,0,      0,0,      1,32'h104,      1,32'h104,0,32'h0,        32'h0));
        vt.push_back(mk(1,0,0,0,      0,0,      1,32'h12345678, 1,32'h108,1,32'h104,      32'h108));
        vt.push_back(mk(1,1,0,0,      0,0,      0,32'h0,        0,32'h10C,1,32'h104,      32'h108));
        vt.push_back(mk(0,0,0,0,      0,0,      0,32'h0,        0,32'h10C,0,32'h0,        32'h0));
        vt.push_back(mk(0,0,0,0,      0,0,      0,32'h0,        1,32'h10C,1,32'h12345678, 32'h10C));

        // Reset state
        @(posedge Clk);
        @(negedge Clk);
        #1;
        chk("rst_req",   {31'b0, ImemReq},   32'h0);
        chk("rst_valid", {31'b0, IfIdValid}, 32'h0);
        chk("rst_instr", IfIdInstr,          32'h0);
        chk("rst_pc4",   IfIdPCPlus4,        32'h0);

        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < vt.size(); i++) begin
            if (i != 0) @(negedge Clk);
            Stall = vt[i].stall; Flush = vt[i].flush;
            BranchTaken = vt[i].br; BranchTarget = vt[i].brt;
            Jump = vt[i].jmp; JumpTarget = vt[i].jt;
            ImemValid = vt[i].vld; ImemRdata = vt[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i),   {31'b0, ImemReq},   {31'b0, vt[i].e_req});
            chk($sformatf("v%0d_addr", i),  ImemAddr,           vt[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'b0, IfIdValid}, {31'b0, vt[i].e_v});
            chk($sformatf("v%0d_instr", i), IfIdInstr,          vt[i].e_instr);
            chk($sformatf("v%0d_pc4", i),   IfIdPCPlus4,        vt[i].e_pc4);
            chk($sformatf("v%0d_imm", i),   {16'h0, IfIdImm16}, {16'h0, vt[i].e_instr[15:0]});
        end

        // Reset mid-request with PC = 0x1C
        cyc(0,0,0,0, 1,32'h1C, 0,32'h0);
        chk("h_jaddr", ImemAddr, 32'h10C);
        cyc(0,0,0,0, 0,0, 1,32'hBAD0BAD0);
        chk("h_disc_addr", ImemAddr, 32'h10C);
        cyc(0,0,0,0, 0,0, 0,32'h0);
        chk("h_1c_addr", ImemAddr, 32'h1C);
        chk("h_1c_req",  {31'b0, ImemReq}, 32'h1);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk("h_rst_req", {31'b0, ImemReq}, 32'h0);

        // After reset: fetch from PC_RESET, then jump to the top of memory
        @(negedge Clk);
        Rst = 1'b0;
        Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC; ImemValid = 1'b1;
        ImemRdata = 32'h0;
        #1;
        chk("h_post_req",   {31'b0, ImemReq},   32'h1);
        chk("h_post_addr",  ImemAddr,           32'h0);
        chk("h_post_valid", {31'b0, IfIdValid}, 32'h0);
        chk("h_post_instr", IfIdInstr,          32'h0);

        cyc(0,0,0,0, 0,0, 1,32'hAAAA5555);
        chk("h_top_addr", ImemAddr, 32'hFFFF_FFFC);
        cyc(0,0,0,0, 0,0, 0,32'h0);
        chk("h_wrap_addr",  ImemAddr,           32'h0);
        chk("h_wrap_valid", {31'b0, IfIdValid}, 32'h1);
        chk("h_wrap_instr", IfIdInstr,          32'hAAAA5555);
        chk("h_wrap_pc4",   IfIdPCPlus4,        32'h0);
        chk("h_wrap_imm",   {16'h0, IfIdImm16}, 32'h5555);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
